pc_fetch_sequencer: RTL and testbench

- Owns the program counter and drives instruction-fetch requests to instruction memory.
- Consumes the 32-bit jump/branch target formed from the PC+4 upper bits and the instr[25:0] field shifted left 2.
- Exports pc_plus4 so target formation can take its top bits.
- Sits between the jump-address formation logic and instruction memory; delivers fetched instructions to decode.

---
 rtl/pc_fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
//==============================================================================
// Module   : pc_fetch_sequencer
// Purpose  : Owns the PC, issues one instruction fetch at a time and hands the
//            returned word to decode. Optional macro: PC_FETCH_MISALIGN_CHECK_EN
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              stall,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misaligned_err
);

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_HOLD    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] issued_pc_q;
    logic              fetch_valid_q;
    logic [31:0]       instr_out_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;

    logic              redir_take_d;
    logic [ADDR_W-1:0] redir_pc_d;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    logic misaligned_err_q;

    // A misaligned redirect is dropped entirely; only the error flag records it.
    assign redir_take_d = redirect_valid && (redirect_addr[1:0] == 2'b00);
    assign redir_pc_d   = redirect_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_err_q <= 1'b0;
        end else if (redirect_valid && (redirect_addr[1:0] != 2'b00)) begin
            misaligned_err_q <= 1'b1;
        end
    end

    assign misaligned_err = misaligned_err_q;
`else
    logic unused_addr_lsbs;

    assign redir_take_d     = redirect_valid;
    assign redir_pc_d       = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsbs = ^redirect_addr[1:0];
    assign misaligned_err   = 1'b0;
`endif

    assign pc_plus4 = pc_q + c_PC_STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            issued_pc_q   <= RESET_PC;
            fetch_valid_q <= 1'b0;
            instr_out_q   <= 32'h0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q       <= S_REQ;
                    fetch_valid_q <= 1'b0;
                    instr_valid_q <= 1'b0;
                    if (redir_take_d) pc_q <= redir_pc_d;
                end
                S_REQ: begin
                    // Decode consumes a delivered word in the first REQ cycle.
                    instr_valid_q <= 1'b0;
                    if (fetch_valid_q && fetch_ready) begin
                        issued_pc_q   <= pc_q;
                        fetch_valid_q <= 1'b0;
                        if (redir_take_d) begin
                            pc_q    <= redir_pc_d;
                            state_q <= S_DISCARD;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (redir_take_d) begin
                        pc_q          <= redir_pc_d;
                        fetch_valid_q <= 1'b0;
                    end else begin
                        fetch_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    instr_valid_q <= 1'b0;
                    if (redir_take_d) begin
                        pc_q    <= redir_pc_d;
                        state_q <= mem_rvalid ? S_REQ : S_DISCARD;
                    end else if (mem_rvalid) begin
                        instr_out_q   <= mem_rdata;
                        instr_pc_q    <= issued_pc_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_plus4;
                        state_q       <= stall ? S_HOLD : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redir_take_d) begin
                        pc_q          <= redir_pc_d;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end else if (!stall) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    instr_valid_q <= 1'b0;
                    if (redir_take_d) pc_q <= redir_pc_d;
                    if (mem_rvalid) state_q <= S_REQ;
                end
                default: begin
                    state_q       <= S_IDLE;
                    fetch_valid_q <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = pc_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
//==============================================================================
// Module   : tb_pc_fetch_sequencer
// Purpose  : Directed self-checking bench for pc_fetch_sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        misaligned_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_sequencer #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_ready   (fetch_ready),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .pc_plus4      (pc_plus4),
        .misaligned_err(misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        stall          = 1'b0;
        fetch_ready    = 1'b0;
        mem_rdata      = 32'h0;
        mem_rvalid     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_err", {31'b0, misaligned_err}, 32'h0);
        reset = 1'b0;

        // IDLE, then first REQ cycle without a request
        chk("idle_fv", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("req0_fv", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("req1_fv", {31'b0, fetch_valid}, 32'h1);
        chk("req1_pc", fetch_pc, 32'h0);
        chk("req1_pc_plus4", pc_plus4, 32'h4);

        // Memory not ready for 5 cycles: request held stable
        for (int i = 0; i < 5; i++) begin
            step();
            chk("notready_fv", {31'b0, fetch_valid}, 32'h1);
            chk("notready_pc", fetch_pc, 32'h0);
            chk("notready_iv", {31'b0, instr_valid}, 32'h0);
        end
        fetch_ready = 1'b1;
        step();
        chk("wait0_fv", {31'b0, fetch_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2000_0001;
        step();
        mem_rvalid = 1'b0;
        chk("d1_iv", {31'b0, instr_valid}, 32'h1);
        chk("d1_out", instr_out, 32'h2000_0001);
        chk("d1_ipc", instr_pc, 32'h0);
        chk("d1_fetch_pc", fetch_pc, 32'h4);
        chk("d1_fv", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("req_b_fv", {31'b0, fetch_valid}, 32'h1);
        chk("req_b_pc", fetch_pc, 32'h4);
        chk("req_b_iv", {31'b0, instr_valid}, 32'h0);

        // Second word delivered under stall: held for 3 stalled cycles
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2000_0002;
        stall      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            mem_rvalid = 1'b0;
            chk("hold_iv", {31'b0, instr_valid}, 32'h1);
            chk("hold_out", instr_out, 32'h2000_0002);
            chk("hold_ipc", instr_pc, 32'h4);
            chk("hold_fv", {31'b0, fetch_valid}, 32'h0);
        end
        stall = 1'b0;
        step();
        chk("unstall_iv", {31'b0, instr_valid}, 32'h0);
        chk("unstall_fv", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("req_c_fv", {31'b0, fetch_valid}, 32'h1);
        chk("req_c_pc", fetch_pc, 32'h8);

        // Redirect while waiting: response for PC 8 dropped
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0400;
        step();
        redirect_valid = 1'b0;
        chk("disc_pc", fetch_pc, 32'h400);
        chk("disc_fv", {31'b0, fetch_valid}, 32'h0);
        chk("disc_iv", {31'b0, instr_valid}, 32'h0);
        step();
        chk("disc_wait_fv", {31'b0, fetch_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("dropped_iv", {31'b0, instr_valid}, 32'h0);
        chk("redir_req_pc", fetch_pc, 32'h400);
        step();
        chk("redir_req_fv", {31'b0, fetch_valid}, 32'h1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        chk("d400_iv", {31'b0, instr_valid}, 32'h1);
        chk("d400_out", instr_out, 32'h1234_5678);
        chk("d400_ipc", instr_pc, 32'h400);
        chk("d400_fetch_pc", fetch_pc, 32'h404);

        // Wrap: fetch at FFFF_FFFC
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        chk("wrap_fv0", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("wrap_fv1", {31'b0, fetch_valid}, 32'h1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        step();
        mem_rvalid = 1'b0;
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_next_pc", fetch_pc, 32'h0);

        // Misaligned redirect
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        chk("mis_err", {31'b0, misaligned_err}, 32'h1);
        chk("mis_pc", fetch_pc, 32'h0);
        chk("mis_fv", {31'b0, fetch_valid}, 32'h1);
        step();
        chk("mis_err_sticky", {31'b0, misaligned_err}, 32'h1);
        chk("mis_pc_hold", fetch_pc, 32'h0);
`else
        chk("mis_err", {31'b0, misaligned_err}, 32'h0);
        chk("mis_pc", fetch_pc, 32'h100);
        chk("mis_fv", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("mis_fv1", {31'b0, fetch_valid}, 32'h1);
        chk("mis_pc_hold", fetch_pc, 32'h100);
`endif
        fetch_ready = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        stall      = 1'b1;
        step();
        mem_rvalid = 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        chk("mis_ipc", instr_pc, 32'h0);
`else
        chk("mis_ipc", instr_pc, 32'h100);
`endif
        chk("mis_hold_iv", {31'b0, instr_valid}, 32'h1);

        // Redirect with stall in HOLD: redirect wins
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0800;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("hold_redir_iv", {31'b0, instr_valid}, 32'h0);
        chk("hold_redir_pc", fetch_pc, 32'h800);
        chk("hold_redir_fv", {31'b0, fetch_valid}, 32'h0);

        // Stray mem_rvalid in REQ is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("stray_iv", {31'b0, instr_valid}, 32'h0);
        chk("stray_fv", {31'b0, fetch_valid}, 32'h1);

        // Redirect concurrent with acceptance, then last-wins in DISCARD
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0C00;
        step();
        chk("acc_redir_pc", fetch_pc, 32'hC00);
        chk("acc_redir_fv", {31'b0, fetch_valid}, 32'h0);
        redirect_addr = 32'h0000_0D00;
        mem_rvalid    = 1'b1;
        mem_rdata     = 32'h6666_6666;
        step();
        redirect_valid = 1'b0;
        mem_rvalid     = 1'b0;
        chk("lastwin_pc", fetch_pc, 32'hD00);
        chk("lastwin_iv", {31'b0, instr_valid}, 32'h0);
        step();
        chk("lastwin_fv", {31'b0, fetch_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
